digit_seq_display: RTL

Parametrised digit-sequence player, the successor to the fixed 3-bit counter-to-digit code converter.
- Holds a programmable sequence of NUM_DIGITS 4-bit digits, with a birth-date style default at reset.
- Steps through the sequence at a prescaled rate or by single-step, forward or backward.
- Drives the selected digit and its active-low 7-segment pattern for the board display.

---
 rtl/digit_seq_display_if.sv | 37 +++
 rtl/digit_seq_display.sv | 139 +++++++++++++
 2 files changed

// File: rtl/digit_seq_display_if.sv
// rtl/digit_seq_display_if.sv - control, write and display bundle for the digit sequence player
//
// Ports grouped here:
//   run, step, dir, rate, last_idx      sequencing controls     (master -> slave)
//   wr_en, wr_addr, wr_data             sequence register write (master -> slave)
//   cur_idx, digit, seg_data, wrap      display outputs         (slave -> master)
// IDX_W is derived from NUM_DIGITS and must match the player instance.

interface digit_seq_if #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_WIDTH  = 16
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                 run;
    logic                 step;
    logic                 dir;
    logic [DIV_WIDTH-1:0] rate;
    logic [IDX_W-1:0]     last_idx;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_addr;
    logic [3:0]           wr_data;
    logic [IDX_W-1:0]     cur_idx;
    logic [3:0]           digit;
    logic [6:0]           seg_data;
    logic                 wrap;

    modport master (
        output run, step, dir, rate, last_idx, wr_en, wr_addr, wr_data,
        input  cur_idx, digit, seg_data, wrap
    );

    modport slave (
        input  run, step, dir, rate, last_idx, wr_en, wr_addr, wr_data,
        output cur_idx, digit, seg_data, wrap
    );
endinterface

// File: rtl/digit_seq_display.sv
// rtl/digit_seq_display.sv - programmable digit-sequence player with 7-segment decode
//
// Ports:
//   clk   rising-edge system clock
//   rst   synchronous reset, active-high
//   bus   digit_seq_if.slave: controls, write port and display outputs
// Optional feature macro: SEQ_HEX_GLYPH_EN
//   defined   -> digits 10-15 show hex glyphs A b C d E F
//   undefined -> digits 10-15 blank the display (digit still carries the raw value)

module digit_seq_display #(
    parameter int                        NUM_DIGITS = 8,
    parameter int                        DIV_WIDTH  = 16,
    parameter logic [4*NUM_DIGITS-1:0]   INIT_SEQ   = 32'h1239_9991
) (
    input  logic      clk,
    input  logic      rst,
    digit_seq_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_DIGITS - 1);
    // One extra bit so the clamp comparison is meaningful even when
    // NUM_DIGITS is a power of two.
    localparam logic [IDX_W:0]   MAX_IDX_EXT = (IDX_W + 1)'(NUM_DIGITS - 1);

    logic [3:0]           seq_q [NUM_DIGITS];
    logic [3:0]           seq_d [NUM_DIGITS];
    logic [IDX_W-1:0]     cur_idx_q, cur_idx_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                 wrap_q, wrap_d;

    logic                 tick;
    logic                 adv;
    logic [IDX_W-1:0]     lim;

    // Prescaler: compare with >= so that lowering rate below the running
    // count produces a tick immediately instead of a long wrap-around.
    always_comb begin
        tick      = 1'b0;
        div_cnt_d = '0;
        if (bus.run) begin
            if (div_cnt_q >= bus.rate) begin
                tick = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    assign adv = bus.run ? tick : bus.step;
    assign lim = ({1'b0, bus.last_idx} > MAX_IDX_EXT) ? MAX_IDX : bus.last_idx;

    always_comb begin
        cur_idx_d = cur_idx_q;
        wrap_d    = 1'b0;
        if (adv) begin
            if (!bus.dir) begin
                if (cur_idx_q >= lim) begin
                    cur_idx_d = '0;
                    wrap_d    = 1'b1;
                end else begin
                    cur_idx_d = cur_idx_q + 1'b1;
                end
            end else begin
                if (cur_idx_q == '0) begin
                    cur_idx_d = lim;
                    wrap_d    = 1'b1;
                end else if (cur_idx_q > lim) begin
                    // Parked beyond the active end: snap back without a wrap.
                    cur_idx_d = lim;
                end else begin
                    cur_idx_d = cur_idx_q - 1'b1;
                end
            end
        end
    end

    // Address match per entry means out-of-range write addresses hit nothing.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seq_d[i] = (bus.wr_en && bus.wr_addr == IDX_W'(i)) ? bus.wr_data : seq_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                seq_q[i] <= INIT_SEQ[4*i +: 4];
            end
            cur_idx_q <= '0;
            div_cnt_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                seq_q[i] <= seq_d[i];
            end
            cur_idx_q <= cur_idx_d;
            div_cnt_q <= div_cnt_d;
            wrap_q    <= wrap_d;
        end
    end

    logic [3:0] digit_w;
    logic [6:0] seg_w;

    assign digit_w = seq_q[cur_idx_q];

    // Active-low {g,f,e,d,c,b,a}
    always_comb begin
        seg_w = 7'h7F;
        case (digit_w)
            4'd0:  seg_w = 7'h40;
            4'd1:  seg_w = 7'h79;
            4'd2:  seg_w = 7'h24;
            4'd3:  seg_w = 7'h30;
            4'd4:  seg_w = 7'h19;
            4'd5:  seg_w = 7'h12;
            4'd6:  seg_w = 7'h02;
            4'd7:  seg_w = 7'h58;
            4'd8:  seg_w = 7'h00;
            4'd9:  seg_w = 7'h10;
`ifdef SEQ_HEX_GLYPH_EN
            4'd10: seg_w = 7'h08;
            4'd11: seg_w = 7'h03;
            4'd12: seg_w = 7'h46;
            4'd13: seg_w = 7'h21;
            4'd14: seg_w = 7'h06;
            4'd15: seg_w = 7'h0E;
`else
            default: seg_w = 7'h7F;
`endif
        endcase
    end

    assign bus.cur_idx  = cur_idx_q;
    assign bus.digit    = digit_w;
    assign bus.seg_data = seg_w;
    assign bus.wrap     = wrap_q;
endmodule
